// File: rtl/nibble_serial_add_ctrl.sv
// Purpose: serial adder, one 4-bit slice per clock, least-significant nibble first.
// Latency: result valid NIBBLES cycles after operand acceptance; NIBBLES+2 cycles minimum per operation.
// Backpressure: in_ready low while busy; the result is held in DONE until out_ready.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           cout_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   sum_q;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [4:0]     add_res;

    // State register; reset returns to IDLE and drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded purely from the current state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the operand nibbles addressed by the slice counter.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // The single 4-bit add slice with carry-in from the previous nibble.
    always_comb begin
        add_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'h0, carry_q};
    end

    // Datapath: latch operands on accept, then deposit one sum nibble per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt_q == CW'(i)) begin
                            sum_q[4*i +: 4] <= add_res[3:0];
                        end
                    end
                    carry_q <= add_res[4];
                    if (cnt_q == LAST) begin
                        cout_q <= add_res[4];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Purpose: directed checks of the serial nibble adder at NIBBLES=4 and NIBBLES=1.
// Latency: stimulus changes 1 time unit after each rising edge; outputs sampled there too.
// Backpressure: exercises held results with out_ready low and ignored in_valid while busy.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst;

    logic        in_valid4;
    logic        in_ready4;
    logic [15:0] in_a4;
    logic [15:0] in_b4;
    logic        out_valid4;
    logic        out_ready4;
    logic [15:0] out_sum4;
    logic        out_cout4;
    logic        busy4;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  in_a1;
    logic [3:0]  in_b1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  out_sum1;
    logic        out_cout1;
    logic        busy1;

    int n_checks;
    int n_fail;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_sum   (out_sum4),
        .out_cout  (out_cout4),
        .busy      (busy4)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_cout  (out_cout1),
        .busy      (busy1)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a 16-bit pair and verify the NIBBLES-edge latency to out_valid.
    task automatic run_op4(input string tag, input logic [15:0] a, input logic [15:0] b);
        in_valid4 = 1'b1;
        in_a4     = a;
        in_b4     = b;
        tick();
        in_valid4 = 1'b0;
        in_a4     = 16'h0;
        in_b4     = 16'h0;
        check({tag, "_busy_run"}, {31'd0, busy4}, 32'd1);
        check({tag, "_inrdy_run"}, {31'd0, in_ready4}, 32'd0);
        tick();
        tick();
        tick();
        check({tag, "_ovld_early"}, {31'd0, out_valid4}, 32'd0);
        tick();
        check({tag, "_ovld"}, {31'd0, out_valid4}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid4  = 1'b0;
        in_a4      = 16'h0;
        in_b4      = 16'h0;
        out_ready4 = 1'b1;
        in_valid1  = 1'b0;
        in_a1      = 4'h0;
        in_b1      = 4'h0;
        out_ready1 = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_inrdy4", {31'd0, in_ready4}, 32'd1);
        check("rst_ovld4", {31'd0, out_valid4}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_sum4", {16'd0, out_sum4}, 32'h0);
        check("rst_cout4", {31'd0, out_cout4}, 32'd0);
        check("rst_inrdy1", {31'd0, in_ready1}, 32'd1);
        check("rst_sum1", {28'd0, out_sum1}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: 1234 + 4321
        run_op4("t1", 16'h1234, 16'h4321);
        check("t1_sum", {16'd0, out_sum4}, 32'h5555);
        check("t1_cout", {31'd0, out_cout4}, 32'd0);
        tick();
        check("t1_idle_inrdy", {31'd0, in_ready4}, 32'd1);
        check("t1_idle_busy", {31'd0, busy4}, 32'd0);
        check("t1_idle_hold", {16'd0, out_sum4}, 32'h5555);

        // 2: carry ripples through every nibble
        run_op4("t2", 16'hFFFF, 16'h0001);
        check("t2_sum", {16'd0, out_sum4}, 32'h0000);
        check("t2_cout", {31'd0, out_cout4}, 32'd1);
        tick();

        // 3: result held under backpressure
        out_ready4 = 1'b0;
        run_op4("t3", 16'h8000, 16'h8000);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_ovld", {31'd0, out_valid4}, 32'd1);
            check("t3_hold_sum", {16'd0, out_sum4}, 32'h0000);
            check("t3_hold_cout", {31'd0, out_cout4}, 32'd1);
            check("t3_hold_inrdy", {31'd0, in_ready4}, 32'd0);
        end
        out_ready4 = 1'b1;
        tick();
        check("t3_release_ovld", {31'd0, out_valid4}, 32'd0);
        check("t3_release_inrdy", {31'd0, in_ready4}, 32'd1);

        // 4: in_valid pulse mid-RUN is ignored
        in_valid4 = 1'b1;
        in_a4     = 16'h00FF;
        in_b4     = 16'h0001;
        tick();
        in_valid4 = 1'b0;
        tick();
        in_valid4 = 1'b1;
        in_a4     = 16'h1111;
        in_b4     = 16'h1111;
        check("t4_pulse_inrdy", {31'd0, in_ready4}, 32'd0);
        tick();
        in_valid4 = 1'b0;
        in_a4     = 16'h0;
        in_b4     = 16'h0;
        tick();
        tick();
        check("t4_ovld", {31'd0, out_valid4}, 32'd1);
        check("t4_sum", {16'd0, out_sum4}, 32'h0100);
        check("t4_cout", {31'd0, out_cout4}, 32'd0);
        tick();
        check("t4_no_extra_op", {31'd0, busy4}, 32'd0);

        // 5: reset during the second RUN cycle aborts the operation
        in_valid4 = 1'b1;
        in_a4     = 16'h1234;
        in_b4     = 16'h4321;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_inrdy", {31'd0, in_ready4}, 32'd1);
        check("t5_ovld", {31'd0, out_valid4}, 32'd0);
        check("t5_sum", {16'd0, out_sum4}, 32'h0);
        check("t5_busy", {31'd0, busy4}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_no_result", {31'd0, out_valid4}, 32'd0);
        end

        // 6: NIBBLES=1, single-edge RUN and 3-cycle back-to-back ops
        in_valid1 = 1'b1;
        in_a1     = 4'hF;
        in_b1     = 4'h1;
        tick();
        in_valid1 = 1'b0;
        check("t6_run_ovld", {31'd0, out_valid1}, 32'd0);
        check("t6_run_busy", {31'd0, busy1}, 32'd1);
        tick();
        check("t6_ovld", {31'd0, out_valid1}, 32'd1);
        check("t6_sum", {28'd0, out_sum1}, 32'h0);
        check("t6_cout", {31'd0, out_cout1}, 32'd1);
        tick();
        check("t6_idle_inrdy", {31'd0, in_ready1}, 32'd1);
        in_valid1 = 1'b1;
        in_a1     = 4'h7;
        in_b1     = 4'h8;
        tick();
        check("t6_b2b_run_inrdy", {31'd0, in_ready1}, 32'd0);
        in_a1     = 4'h9;
        in_b1     = 4'h9;
        tick();
        check("t6_b2b_ovld_a", {31'd0, out_valid1}, 32'd1);
        check("t6_b2b_sum_a", {28'd0, out_sum1}, 32'hF);
        check("t6_b2b_cout_a", {31'd0, out_cout1}, 32'd0);
        tick();
        check("t6_b2b_idle_ovld", {31'd0, out_valid1}, 32'd0);
        check("t6_b2b_idle_inrdy", {31'd0, in_ready1}, 32'd1);
        tick();
        in_valid1 = 1'b0;
        check("t6_b2b_run_ovld", {31'd0, out_valid1}, 32'd0);
        tick();
        check("t6_b2b_ovld_b", {31'd0, out_valid1}, 32'd1);
        check("t6_b2b_sum_b", {28'd0, out_sum1}, 32'h2);
        check("t6_b2b_cout_b", {31'd0, out_cout1}, 32'd1);
        tick();
        check("t6_end_busy", {31'd0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
